cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter_pkg.sv | 20 ++
 rtl/cache_arbiter_sat_counter.sv | 22 ++
 rtl/cache_arbiter.sv | 123 ++++++++++++
 tb/tb_cache_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared CPU package: arbiter FSM encodings, port indices and the latched cache command.
package cache_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] din;
    } cache_cmd_t;

endpackage

// File: rtl/cache_arbiter_sat_counter.sv
// Saturating event counter: counts inc pulses and holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (inc && (r_count != {WIDTH{1'b1}}))
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    assign count = r_count;

endmodule

// File: rtl/cache_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-request cache.
// One transaction outstanding at a time; ties alternate between ports.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req_valid,
    input  logic [31:0]          if_addr,
    output logic                 if_req_ready,
    output logic                 if_resp_valid,
    input  logic                 d_req_valid,
    input  logic [31:0]          d_addr,
    input  logic                 d_mem_read,
    input  logic                 d_mem_write,
    input  logic [31:0]          d_din,
    output logic                 d_req_ready,
    output logic                 d_resp_valid,
    output logic [31:0]          resp_dout,
    output logic                 resp_hit,
    output logic                 c_is_input_valid,
    output logic                 c_mem_read,
    output logic                 c_mem_write,
    output logic [31:0]          c_addr,
    output logic [31:0]          c_din,
    input  logic                 c_is_ready,
    input  logic                 c_is_output_valid,
    input  logic                 c_is_hit,
    input  logic [31:0]          c_dout,
    output logic [CNT_WIDTH-1:0] if_grant_cnt,
    output logic [CNT_WIDTH-1:0] d_grant_cnt,
    output logic [CNT_WIDTH-1:0] hit_cnt
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_grant;
    logic       r_owner;
    cache_cmd_t r_cmd;
    cache_cmd_t w_cmd_in;
    logic       w_sel_d;
    logic       w_sel_if;
    logic       w_if_xfer;
    logic       w_d_xfer;
    logic       w_xfer;
    logic       w_resp;

    // Only a requesting port can be selected; a tie goes to the port not granted last.
    assign w_sel_d  = d_req_valid && (!if_req_valid || (r_last_grant == PORT_IF));
    assign w_sel_if = if_req_valid && !w_sel_d;

    assign w_if_xfer = if_req_valid && if_req_ready;
    assign w_d_xfer  = d_req_valid && d_req_ready;
    assign w_xfer    = w_if_xfer || w_d_xfer;

    // Instruction fetches are always plain reads.
    always_comb begin
        w_cmd_in = '{addr: if_addr, mem_read: 1'b1, mem_write: 1'b0, din: 32'd0};
        if (w_d_xfer)
            w_cmd_in = '{addr: d_addr, mem_read: d_mem_read, mem_write: d_mem_write, din: d_din};
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_xfer) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (c_is_output_valid) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Gating on reset keeps a mid-transaction reset from leaking a ready or response.
    always_comb begin
        if_req_ready     = (r_state == ST_IDLE) && !reset && c_is_ready && w_sel_if;
        d_req_ready      = (r_state == ST_IDLE) && !reset && c_is_ready && w_sel_d;
        c_is_input_valid = (r_state == ST_ISSUE);
        w_resp           = (r_state == ST_WAIT) && c_is_output_valid && !reset;
        if_resp_valid    = w_resp && (r_owner == PORT_IF);
        d_resp_valid     = w_resp && (r_owner == PORT_D);
        resp_dout        = w_resp ? c_dout : 32'd0;
        resp_hit         = w_resp && c_is_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd        <= '0;
            r_owner      <= PORT_IF;
            r_last_grant <= PORT_IF;
        end else if (w_xfer) begin
            r_cmd        <= w_cmd_in;
            r_owner      <= w_d_xfer ? PORT_D : PORT_IF;
            r_last_grant <= w_d_xfer ? PORT_D : PORT_IF;
        end
    end

    assign c_addr      = r_cmd.addr;
    assign c_mem_read  = r_cmd.mem_read;
    assign c_mem_write = r_cmd.mem_write;
    assign c_din       = r_cmd.din;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_if_grant_cnt (
        .clk(clk), .reset(reset), .inc(w_if_xfer), .count(if_grant_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_d_grant_cnt (
        .clk(clk), .reset(reset), .inc(w_d_xfer), .count(d_grant_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk(clk), .reset(reset), .inc(w_resp && c_is_hit), .count(hit_cnt)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a small direct-mapped cache model answers requests,
// stimulus pushes hand-computed expectations and a negedge monitor scores the DUT.
module tb_cache_arbiter;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req_valid, d_req_valid, d_mem_read, d_mem_write;
    logic [31:0]   if_addr, d_addr, d_din;
    logic          if_req_ready, if_resp_valid, d_req_ready, d_resp_valid;
    logic [31:0]   resp_dout, c_addr, c_din, c_dout;
    logic          resp_hit, c_is_input_valid, c_mem_read, c_mem_write;
    logic          c_is_ready, c_is_output_valid, c_is_hit;
    logic [CW-1:0] if_grant_cnt, d_grant_cnt, hit_cnt;

    always #5 clk = ~clk;

    cache_arbiter #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid),
        .d_req_valid(d_req_valid), .d_addr(d_addr), .d_mem_read(d_mem_read),
        .d_mem_write(d_mem_write), .d_din(d_din), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .resp_dout(resp_dout), .resp_hit(resp_hit),
        .c_is_input_valid(c_is_input_valid), .c_mem_read(c_mem_read),
        .c_mem_write(c_mem_write), .c_addr(c_addr), .c_din(c_din),
        .c_is_ready(c_is_ready), .c_is_output_valid(c_is_output_valid),
        .c_is_hit(c_is_hit), .c_dout(c_dout),
        .if_grant_cnt(if_grant_cnt), .d_grant_cnt(d_grant_cnt), .hit_cnt(hit_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // ---------------- cache model: 64 one-word lines, write-back, write-allocate
    typedef struct packed {
        logic        v;
        logic        d;
        logic [23:0] tag;
        logic [31:0] data;
    } line_t;

    line_t       lines [64];
    logic [31:0] mem [logic [31:0]];
    bit          m_loaded = 1'b0;
    logic        m_busy, m_ov, m_hit, tb_stall;
    logic [31:0] m_dout;
    int          m_cnt;

    assign c_is_ready        = !m_busy && !tb_stall;
    assign c_is_output_valid = m_ov;
    assign c_is_hit          = m_hit;
    assign c_dout            = m_dout;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_ov   <= 1'b0;
            m_hit  <= 1'b0;
            m_dout <= 32'd0;
            m_cnt  <= 0;
            if (!m_loaded) begin
                for (int i = 0; i < 64; i++) lines[i] <= '0;
                lines[0] <= '{1'b1, 1'b0, 24'h1, 32'h11111111};
                lines[1] <= '{1'b1, 1'b0, 24'h1, 32'h22222222};
                m_loaded <= 1'b1;
            end
        end else begin
            m_ov <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin m_ov <= 1'b1; m_busy <= 1'b0; end
                else m_cnt <= m_cnt - 1;
            end
            if (c_is_input_valid) begin
                automatic logic [5:0]  idx = c_addr[7:2];
                automatic line_t       ln  = lines[idx];
                automatic logic        hit = ln.v && (ln.tag == c_addr[31:8]);
                automatic int          dly = 1;
                automatic logic [31:0] fetched;
                if (!hit) begin
                    dly = 5;
                    if (ln.v && ln.d) begin
                        mem[{ln.tag, idx, 2'b00}] = ln.data;
                        dly = 7;
                    end
                    fetched = mem.exists(c_addr) ? mem[c_addr] : {c_addr[15:0], 16'hC0DE};
                    ln = '{1'b1, 1'b0, c_addr[31:8], fetched};
                end
                if (c_mem_write) begin
                    ln.data = c_din;
                    ln.d    = 1'b1;
                    m_dout <= 32'd0;
                end else begin
                    m_dout <= ln.data;
                end
                lines[idx] <= ln;
                m_hit  <= hit;
                m_cnt  <= dly;
                m_busy <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard
    typedef struct { logic [31:0] addr; logic rd; logic wr; logic [31:0] din; } cmd_t;
    typedef struct { logic port; logic [31:0] dout; logic hit; } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   acc_q[$];
    cmd_t cur;
    rsp_t r;
    bit   outst = 1'b0;
    int   t_iv = 0;
    int   last_acc = 0;

    always @(negedge clk) begin
        if (reset) begin
            outst = 1'b0;
        end else begin
            if (outst) begin
                chk("busy_if_ready", 32'(if_req_ready), 32'd0);
                chk("busy_d_ready", 32'(d_req_ready), 32'd0);
                chk("hold_addr", c_addr, cur.addr);
                chk("hold_rw", 32'({c_mem_read, c_mem_write}), 32'({cur.rd, cur.wr}));
                chk("hold_din", c_din, cur.din);
            end
            if (c_is_input_valid) begin
                chk("issue_expected", 32'(cmd_q.size() != 0), 32'd1);
                if (cmd_q.size() != 0) begin
                    cur   = cmd_q.pop_front();
                    outst = 1'b1;
                    t_iv  = cyc;
                    chk("issue_lat", 32'(cyc - last_acc), 32'd1);
                    chk("issue_addr", c_addr, cur.addr);
                    chk("issue_rw", 32'({c_mem_read, c_mem_write}), 32'({cur.rd, cur.wr}));
                    chk("issue_din", c_din, cur.din);
                end
            end
            if (if_resp_valid || d_resp_valid) begin
                chk("resp_onehot", 32'(if_resp_valid && d_resp_valid), 32'd0);
                chk("resp_expected", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    chk("resp_port", 32'(d_resp_valid), 32'(r.port));
                    chk("resp_dout", resp_dout, r.dout);
                    chk("resp_hit", 32'(resp_hit), 32'(r.hit));
                    if (r.hit) chk("hit_lat", 32'(cyc - t_iv), 32'd2);
                end
                outst = 1'b0;
            end else begin
                chk("idle_dout", resp_dout, 32'd0);
                chk("idle_hit", 32'(resp_hit), 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic send(input logic port, input logic [31:0] addr, input logic rd,
                        input logic wr, input logic [31:0] din, input logic [31:0] edout,
                        input logic ehit, input bit push);
        int n = 0;
        logic rdy;
        if (push) begin
            cmd_q.push_back('{addr, rd, wr, din});
            rsp_q.push_back('{port, edout, ehit});
        end
        @(negedge clk);
        if (port) begin
            d_req_valid = 1'b1; d_addr = addr; d_mem_read = rd; d_mem_write = wr; d_din = din;
        end else begin
            if_req_valid = 1'b1; if_addr = addr;
        end
        forever begin
            #1;
            rdy = port ? d_req_ready : if_req_ready;
            if (rdy || n > 100) break;
            n++;
            @(negedge clk);
        end
        if (!rdy) chk("accept_timeout", 32'(rdy), 32'd1);
        last_acc = cyc;
        acc_q.push_back(cyc);
        @(negedge clk);
        // Scramble the request lines: the latched command must not follow them.
        if (port) begin
            d_req_valid = 1'b0; d_addr = ~addr; d_mem_read = ~rd; d_mem_write = ~wr; d_din = ~din;
        end else begin
            if_req_valid = 1'b0; if_addr = ~addr;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (rsp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (rsp_q.size() != 0) begin
            chk("resp_timeout", 32'(rsp_q.size()), 32'd0);
            rsp_q.delete();
            cmd_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string tag, input int e_if, input int e_d, input int e_hit);
        chk({tag, "_if_cnt"}, 32'(if_grant_cnt), 32'(e_if));
        chk({tag, "_d_cnt"}, 32'(d_grant_cnt), 32'(e_d));
        chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(e_hit));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; if_req_valid = 1'b1; d_req_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_if_ready", 32'(if_req_ready), 32'd0);
        chk("rst_d_ready", 32'(d_req_ready), 32'd0);
        chk("rst_resp", 32'({if_resp_valid, d_resp_valid}), 32'd0);
        @(negedge clk);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_c_valid", 32'({c_is_input_valid, c_mem_read, c_mem_write}), 32'd0);
        chk("rst_c_addr", c_addr, 32'd0);
        chk("rst_c_din", c_din, 32'd0);
        chk("rst_resp_out", resp_dout | 32'(resp_hit), 32'd0);
        chk_cnt("rst", 0, 0, 0);
    endtask

    // ---------------- directed sequence
    initial begin
        reset = 1'b1; tb_stall = 1'b0;
        if_req_valid = 1'b0; if_addr = 32'd0;
        d_req_valid = 1'b0; d_addr = 32'd0; d_mem_read = 1'b0; d_mem_write = 1'b0; d_din = 32'd0;
        do_reset();

        // A request withdrawn while the cache stalls leaves no trace.
        tb_stall = 1'b1;
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h40;
        #1 chk("stall_ready", 32'(if_req_ready), 32'd0);
        @(negedge clk);
        if_req_valid = 1'b0; tb_stall = 1'b0;
        repeat (4) @(negedge clk);
        chk_cnt("discard", 0, 0, 0);

        // Single data-port hit.
        send(1'b1, 32'h100, 1'b1, 1'b0, 32'd0, 32'h11111111, 1'b1, 1'b1);
        wait_done();
        chk_cnt("single", 0, 1, 1);

        // Tie after reset: D, IF, D, IF at four-cycle spacing.
        do_reset();
        acc_q.delete();
        cmd_q.push_back('{32'h100, 1'b1, 1'b0, 32'd0}); rsp_q.push_back('{1'b1, 32'h11111111, 1'b1});
        cmd_q.push_back('{32'h104, 1'b1, 1'b0, 32'd0}); rsp_q.push_back('{1'b0, 32'h22222222, 1'b1});
        cmd_q.push_back('{32'h104, 1'b1, 1'b0, 32'd0}); rsp_q.push_back('{1'b1, 32'h22222222, 1'b1});
        cmd_q.push_back('{32'h100, 1'b1, 1'b0, 32'd0}); rsp_q.push_back('{1'b0, 32'h11111111, 1'b1});
        fork
            begin
                send(1'b1, 32'h100, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
                send(1'b1, 32'h104, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            end
            begin
                send(1'b0, 32'h104, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
                send(1'b0, 32'h100, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            end
        join
        wait_done();
        chk("tie_grants", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i + 1 < acc_q.size(); i++)
            chk("tie_gap", 32'(acc_q[i+1] - acc_q[i]), 32'd4);
        chk_cnt("tie", 2, 2, 3);

        // Instruction fetch of 0x0 with hostile data-port lines idling: forced read, din 0.
        d_addr = 32'h1234; d_mem_read = 1'b0; d_mem_write = 1'b1; d_din = 32'hFFFFFFFF;
        send(1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 32'h0000C0DE, 1'b0, 1'b1);
        wait_done();
        chk("if_cnt_sat", 32'(if_grant_cnt), 32'd3);

        // Write-allocate, dirty eviction by a conflicting read, then read back.
        send(1'b1, 32'h200, 1'b0, 1'b1, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
        wait_done();
        send(1'b1, 32'h1200, 1'b1, 1'b0, 32'd0, 32'h1200C0DE, 1'b0, 1'b1);
        wait_done();
        send(1'b1, 32'h200, 1'b1, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_done();

        // Reset while waiting on a miss: no response, then a clean transaction.
        cmd_q.push_back('{32'h300, 1'b1, 1'b0, 32'd0});
        send(1'b1, 32'h300, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        send(1'b1, 32'h104, 1'b1, 1'b0, 32'd0, 32'h22222222, 1'b1, 1'b1);
        wait_done();
        chk_cnt("post_abort", 0, 1, 1);

        // Saturation of the 2-bit counters over five hits.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 32'h104, 1'b1, 1'b0, 32'd0, 32'h22222222, 1'b1, 1'b1);
            wait_done();
            if (i == 1) chk_cnt("sat_mid", 0, 2, 2);
        end
        chk_cnt("sat_end", 0, 3, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
